// File: rtl/adc_capture_gate.sv
// adc_capture_gate
//
// Pretrigger capture gate for one ADC AXI4-Stream in the aclk domain.
// Keeps a rolling history of the last PRE_BEATS valid input beats. When
// capture_i is accepted, it emits a packet of exactly LENGTH beats. The
// packet starts PRE_BEATS beats before the request and ends with tlast.
// The ADC side cannot be stalled. If the downstream buffer holds off, the
// held output beat is overwritten, and the loss is recorded in overflow_o.
//
// Optional build macro: ADC_CAPTURE_STATS_EN
//   defined   : capture_count_o / drop_count_o are live counters
//   undefined : both count ports are tied to zero
//
// Ports
//   aclk, areset      clock, synchronous active-high reset
//   capture_i         single-cycle capture request
//   s_axis_*          input stream (tready is constant 1)
//   m_axis_*          output stream toward the readout buffer
//   busy_o            FSM not in IDLE
//   done_o            pulses on the cycle the tlast beat is accepted
//   overflow_o        sticky drop flag, cleared at each accepted capture
//   capture_count_o   accepted captures (wrapping)
//   drop_count_o      dropped beats (saturating)

module adc_capture_gate #(
  parameter int DATA_WIDTH = 128,
  parameter int PRE_BEATS  = 16,
  parameter int LENGTH     = 1024
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  capture_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic [31:0]           capture_count_o,
  output logic [15:0]           drop_count_o
);

  localparam int PTR_W = (PRE_BEATS > 1) ? $clog2(PRE_BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [7:0]              prime_cnt;
  logic                    primed;
  logic [DATA_WIDTH-1:0]   delayed_p0;
  logic [15:0]             beat_cnt;
  logic [15:0]             load_idx;
  logic                    load_last;
  logic                    start;
  logic                    load;
  logic                    accept;
  logic                    drop;
  logic [DATA_WIDTH-1:0]   out_data_p1;
  logic                    out_vld_p1;
  logic                    out_last_p1;
  logic                    overflow_q;

  assign s_axis_tready = 1'b1;

  // Prime counter: the history is trustworthy only after PRE_BEATS valid
  // beats have been written since reset.
  assign primed = (prime_cnt == 8'(PRE_BEATS));

  always_ff @(posedge aclk) begin
    if (areset) begin
      prime_cnt <= 8'd0;
    end else if (s_axis_tvalid && !primed) begin
      prime_cnt <= prime_cnt + 8'd1;
    end
  end

  // ---- stage p0: history delay line ----
  generate
    if (PRE_BEATS == 0) begin : g_no_hist
      assign delayed_p0 = s_axis_tdata;
    end else begin : g_hist
      logic [DATA_WIDTH-1:0] mem [PRE_BEATS];
      logic [PTR_W-1:0]      wr_ptr;
      logic [PTR_W-1:0]      ptr_nxt;
      logic [DATA_WIDTH-1:0] hist_rd_p0;

      always_comb begin
        ptr_nxt = (wr_ptr == PTR_W'(PRE_BEATS - 1)) ? '0 : wr_ptr + 1'b1;
      end

      always_ff @(posedge aclk) begin
        if (s_axis_tvalid) begin
          mem[wr_ptr] <= s_axis_tdata;
        end
      end

      always_ff @(posedge aclk) begin
        if (areset) begin
          wr_ptr <= '0;
        end else if (s_axis_tvalid) begin
          wr_ptr <= ptr_nxt;
        end
      end

      // Pre-read: the read register always holds the entry at wr_ptr.
      // That entry is the beat the next valid input will displace, so the
      // delayed beat is ready in the same cycle as its input. With a
      // single-entry line, the next slot is the one being written now, so
      // the incoming beat is forwarded instead.
      always_ff @(posedge aclk) begin
        if (s_axis_tvalid) begin
          hist_rd_p0 <= (ptr_nxt == wr_ptr) ? s_axis_tdata : mem[ptr_nxt];
        end
      end

      assign delayed_p0 = hist_rd_p0;
    end
  endgenerate

  // Capture control
  assign start     = (state_q == IDLE) && capture_i && primed;
  assign load      = s_axis_tvalid && ((state_q == RUN) || start);
  assign load_idx  = (state_q == IDLE) ? 16'd0 : beat_cnt;
  assign load_last = (load_idx == 16'(LENGTH - 1));
  assign accept    = out_vld_p1 && m_axis_tready;
  assign drop      = load && out_vld_p1 && !m_axis_tready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (load && load_last) ? DRAIN : RUN;
      RUN:     if (load && load_last) state_d = DRAIN;
      DRAIN:   if (accept && out_last_p1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q != IDLE);
    done_o = (state_q == DRAIN) && accept && out_last_p1;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      beat_cnt <= 16'd0;
    end else if (load) begin
      beat_cnt <= load_idx + 16'd1;
    end else if (start) begin
      beat_cnt <= 16'd0;
    end
  end

  // ---- stage p1: output register ----
  // A load always wins. If the held beat was not accepted, it is
  // overwritten, together with its tlast.
  always_ff @(posedge aclk) begin
    if (areset) begin
      out_vld_p1  <= 1'b0;
      out_last_p1 <= 1'b0;
      out_data_p1 <= '0;
    end else if (load) begin
      out_vld_p1  <= 1'b1;
      out_last_p1 <= load_last;
      out_data_p1 <= delayed_p0;
    end else if (accept) begin
      out_vld_p1  <= 1'b0;
      out_last_p1 <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (start) begin
      overflow_q <= 1'b0;
    end
  end

  assign m_axis_tdata  = out_data_p1;
  assign m_axis_tvalid = out_vld_p1;
  assign m_axis_tlast  = out_last_p1;
  assign overflow_o    = overflow_q;

`ifdef ADC_CAPTURE_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [31:0] capture_cnt_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      capture_cnt_q <= 32'd0;
      drop_cnt_q    <= 16'd0;
    end else begin
      if (start) capture_cnt_q <= capture_cnt_q + 32'd1;
      if (drop)  drop_cnt_q    <= sat_inc16(drop_cnt_q);
    end
  end

  assign capture_count_o = capture_cnt_q;
  assign drop_count_o    = drop_cnt_q;
`else
  assign capture_count_o = 32'd0;
  assign drop_count_o    = 16'd0;
`endif

endmodule

// File: doc/adc_capture_gate.md
# adc_capture_gate

Pretrigger capture gate for one 128-bit ADC AXI4-Stream, in the `aclk` domain. It sits between the RFDC ADC stream (or a design-processed stream) and the readout-buffer input (`S_AXIS_n`). On a capture request it emits exactly `LENGTH` beats, including `PRE_BEATS` beats of history recorded before the request, and terminates the packet with `tlast`.

## Interface
Parameters:
- `DATA_WIDTH`, 128, stream width in bits.
- `PRE_BEATS`, 16, pretrigger history depth in beats. Range 0..255.
- `LENGTH`, 1024, beats per capture packet. Range (`PRE_BEATS`+1)..65535.

Ports:
- `aclk`  in  1  stream clock.
- `areset`  in  1  synchronous, active-high reset.
- `capture_i`  in  1  capture request, single-cycle pulse, already synchronous to `aclk`.
- `s_axis_tdata`  in  `DATA_WIDTH`  input samples.
- `s_axis_tvalid`  in  1  input beat valid.
- `s_axis_tready`  out  1  constant 1; the ADC cannot be stalled.
- `m_axis_tdata`  out  `DATA_WIDTH`  output samples.
- `m_axis_tvalid`  out  1  output beat valid.
- `m_axis_tready`  in  1  buffer accepts the output beat.
- `m_axis_tlast`  out  1  final beat of a packet.
- `busy_o`  out  1  state is not IDLE.
- `done_o`  out  1  one-cycle pulse when the `tlast` beat is accepted.
- `overflow_o`  out  1  sticky drop flag; cleared at the start of each accepted capture.
- `capture_count_o`  out  32  accepted captures (see Configuration).
- `drop_count_o`  out  16  beats dropped, saturating (see Configuration).

## Operation
- History:
  - A delay line of `PRE_BEATS` entries, built from RAM or SRL, advances only on `s_axis_tvalid`.
  - A prime counter counts valid beats after reset, saturating at `PRE_BEATS`. The gate is primed when the counter equals `PRE_BEATS`; with `PRE_BEATS`=0 it is always primed.
  - Delayed beat = input beat from `PRE_BEATS` valid beats earlier.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN when `capture_i`=1 and primed. Beat counter clears to 0 and `overflow_o` clears.
  - `capture_i` is ignored in IDLE when unprimed, and ignored in RUN and DRAIN. No queueing.
  - RUN: every valid input beat, starting with the beat on the capture cycle itself if valid, loads its delayed beat into the output register.
    - The beat counter increments on each load.
    - The load with count `LENGTH`-1 sets `tlast`, then RUN -> DRAIN.
  - DRAIN -> IDLE on `m_axis_tvalid && m_axis_tready` with `tlast`=1. `done_o` pulses on that cycle.
- Output register, 1 entry:
  - A load while empty, or while the current beat is being accepted, is normal.
  - A load while `m_axis_tvalid`=1 and `m_axis_tready`=0 overwrites the held beat, including its `tlast`. The held beat is lost, `overflow_o` sets and the drop count increments.
  - The packet therefore always spans `LENGTH` input beats in time and always ends with `tlast`.
- Arithmetic: beat counter 16 bits. `capture_count_o` wraps. `drop_count_o` saturates at 0xFFFF.

## Timing
- Reset values: `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `busy_o`=0, `done_o`=0, `overflow_o`=0, both counts 0, prime counter 0, state IDLE.
- Latency: an input beat at cycle t appears on `m_axis` at cycle t+1 (registered). `busy_o` rises the cycle after `capture_i`.
- The delay-line read is registered internally. It must still meet this 1-cycle data latency, so the history is pre-read.
- Gapped `s_axis_tvalid`: no output beat is produced for gap cycles. The packet length is unaffected.
- `areset` asserted mid-RUN or mid-DRAIN: the cycle after, all outputs are at reset values and the partial packet is abandoned with no `tlast`. The gate must re-prime before the next capture.
- `m_axis_tvalid` must never drop without acceptance, except by overwrite or reset.

## Configuration
- `ADC_CAPTURE_STATS_EN`
  - Defined: `capture_count_o` and `drop_count_o` are live counters, reset by `areset` only.
  - Undefined: both ports are tied to 0 and no counter logic is synthesised. All other behaviour, including `overflow_o`, is identical.

## Test plan
All scenarios use `PRE_BEATS`=16, `LENGTH`=64, continuous `s_axis_tvalid`, data = beat index since reset, `m_axis_tready`=1 unless stated otherwise.
- Capture on beat 40 -> 64 beats with data 24..87, `tlast` on 87, `done_o` pulses once, `busy_o` low the cycle after.
- Capture on beat 5 (unprimed) -> no output and `busy_o` stays 0. A capture on beat 40 afterwards works as in the first scenario.
- `m_axis_tready`=0 for 3 cycles mid-packet -> `overflow_o`=1 and 3 beats lost. The packet still ends with data 87 and `tlast`; `drop_count_o`=3 with the macro defined.
- Second `capture_i` during RUN -> ignored; exactly one packet; `capture_count_o`=1.
- `s_axis_tvalid` toggling 1,0 -> 64 output beats with consecutive data 24..87, spaced 2 cycles apart.
- `areset` at packet beat 30 -> `m_axis_tvalid`=0 next cycle. A capture 10 beats after reset is ignored (unprimed).
